fa_resp_checker: RTL and testbench

Synthesizable response checker for the full-adder datapath: the receiving end of the adder stimulus sequence. It samples each applied operand vector together with the DUT's `co`/`s` outputs and compares them against a golden model. It tracks pass/error counts and coverage of every input combination, and reports completion or failure. It sits beside the adder under test in on-chip self-test builds and in simulation harnesses.

---
 rtl/fa_chk_pkg.sv | 25 ++
 rtl/fa_golden.sv | 15 +
 rtl/fa_resp_checker.sv | 123 ++++++++++++
 tb/tb_fa_resp_checker.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fa_chk_pkg.sv
// Shared types and golden arithmetic for the full-adder response checker.
// Operand widths up to MAX_W are supported by the shared expect function.
package fa_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE,
    ST_FAIL
  } state_e;

  localparam int MAX_W = 4;

  function automatic int fa_vec_width(input int w);
    return 2 * w + 1;
  endfunction

  // Evaluated at MAX_W so one function serves every legal W; callers zero-extend.
  function automatic logic [MAX_W:0] fa_expect(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{MAX_W{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/fa_golden.sv
// Combinational reference adder: produces the expected {co,s} for one vector.
module fa_golden
  import fa_chk_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W:0]   sum_o
);

  assign sum_o = (W+1)'(fa_expect(MAX_W'(a_i), MAX_W'(b_i), cin_i));

endmodule

// File: rtl/fa_resp_checker.sv
// Full-adder response checker: compares DUT {co,s} with a golden model and tracks coverage.
// Optional macro FA_CHK_STOP_ON_ERR_EN: the first mismatch ends the run in FAIL.
module fa_resp_checker
  import fa_chk_pkg::*;
#(
  parameter  int W  = 1,
  parameter  int CW = 8,
  localparam int VW = fa_vec_width(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          vld,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          cin,
  input  logic          co,
  input  logic [W-1:0]  s,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] err_cnt,
  output logic          cov_full,
  output logic [VW-1:0] first_err_vec,
  output logic [W:0]    first_err_got
);

  localparam int NV = 1 << VW;

  state_e          state_q, state_d;
  logic [CW-1:0]   pass_q,  pass_d;
  logic [CW-1:0]   err_q,   err_d;
  logic            fail_q,  fail_d;
  logic [NV-1:0]   cov_q,   cov_d;
  logic [VW-1:0]   fvec_q,  fvec_d;
  logic [W:0]      fgot_q,  fgot_d;

  logic [W:0]      expect_sum;
  logic [VW-1:0]   vec;
  logic [W:0]      got;
  logic            mismatch;

  fa_golden #(.W(W)) u_golden (
    .a_i   (a),
    .b_i   (b),
    .cin_i (cin),
    .sum_o (expect_sum)
  );

  assign vec      = {a, b, cin};
  assign got      = {co, s};
  assign mismatch = (got != expect_sum);

  // NOTE: every _d gets its current value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    cov_d   = cov_q;
    fvec_d  = fvec_q;
    fgot_d  = fgot_q;

    if (start) begin
      // A sample presented together with start belongs to no run and is dropped.
      state_d = ST_RUN;
      pass_d  = '0;
      err_d   = '0;
      fail_d  = 1'b0;
      cov_d   = '0;
      fvec_d  = '0;
      fgot_d  = '0;
    end else if (vld && state_q == ST_RUN) begin
      if (mismatch) begin
        if (err_q != {CW{1'b1}}) err_d = err_q + 1'b1;
        if (!fail_q) begin
          fail_d = 1'b1;
          fvec_d = vec;
          fgot_d = got;
        end
      end else if (pass_q != {CW{1'b1}}) begin
        pass_d = pass_q + 1'b1;
      end
      cov_d[vec] = 1'b1;
      if (&cov_d) state_d = (err_d == '0) ? ST_DONE : ST_FAIL;
`ifdef FA_CHK_STOP_ON_ERR_EN
      if (mismatch) state_d = ST_FAIL;
`endif
    end
  end

  // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pass_q  <= '0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      cov_q   <= '0;
      fvec_q  <= '0;
      fgot_q  <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      cov_q   <= cov_d;
      fvec_q  <= fvec_d;
      fgot_q  <= fgot_d;
    end
  end

  assign busy          = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);
  assign fail          = fail_q;
  assign pass_cnt      = pass_q;
  assign err_cnt       = err_q;
  assign cov_full      = &cov_q;
  assign first_err_vec = fvec_q;
  assign first_err_got = fgot_q;

endmodule

// File: tb/tb_fa_resp_checker.sv
// Scoreboard bench for fa_resp_checker (W=1) with a second CW=2 instance for saturation.
module tb_fa_resp_checker;

  localparam int W  = 1;
  localparam int VW = 2 * W + 1;
  localparam int NV = 1 << VW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, vld = 1'b0, cin = 1'b0, co = 1'b0;
  logic [W-1:0] a = '0, b = '0, s = '0;

  logic         d_busy, d_done, d_fail, d_cov;
  logic [7:0]   d_pass, d_err;
  logic [VW-1:0] d_fvec;
  logic [W:0]   d_fgot;

  logic         t_busy, t_done, t_fail, t_cov;
  logic [1:0]   t_pass, t_err;
  logic [VW-1:0] t_fvec;
  logic [W:0]   t_fgot;

  fa_resp_checker #(.W(W), .CW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
    .a(a), .b(b), .cin(cin), .co(co), .s(s),
    .busy(d_busy), .done(d_done), .fail(d_fail),
    .pass_cnt(d_pass), .err_cnt(d_err), .cov_full(d_cov),
    .first_err_vec(d_fvec), .first_err_got(d_fgot)
  );

  fa_resp_checker #(.W(W), .CW(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
    .a(a), .b(b), .cin(cin), .co(co), .s(s),
    .busy(t_busy), .done(t_done), .fail(t_fail),
    .pass_cnt(t_pass), .err_cnt(t_err), .cov_full(t_cov),
    .first_err_vec(t_fvec), .first_err_got(t_fgot)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit busy, done, fail, cov_full;
    int pass8, err8, pass2, err2, fvec, fgot;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: plain integers and a seen-vector table.
  bit m_busy, m_done, m_fail;
  int m_pass[2], m_err[2];
  int cap[2] = '{255, 3};
  bit m_seen[NV];
  int m_fvec, m_fgot;

  function automatic int good_sum(input int av, input int bv, input int cv);
    return av + bv + cv;
  endfunction

  function automatic bit all_seen();
    for (int i = 0; i < NV; i++) if (!m_seen[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    m_done = 0; m_fail = 0; m_fvec = 0; m_fgot = 0;
    for (int k = 0; k < 2; k++) begin m_pass[k] = 0; m_err[k] = 0; end
    for (int i = 0; i < NV; i++) m_seen[i] = 0;
  endtask

  task automatic model_step(input bit st, input bit v, input int av, input int bv,
                            input int cv, input int got);
    if (st) begin
      model_clear();
      m_busy = 1;
    end else if (m_busy && v) begin
      int idx;
      bit bad;
      idx = (av << (W + 1)) | (bv << 1) | cv;
      bad = (got != good_sum(av, bv, cv));
      for (int k = 0; k < 2; k++) begin
        if (bad) m_err[k] = (m_err[k] < cap[k]) ? m_err[k] + 1 : cap[k];
        else     m_pass[k] = (m_pass[k] < cap[k]) ? m_pass[k] + 1 : cap[k];
      end
      if (bad && !m_fail) begin m_fail = 1; m_fvec = idx; m_fgot = got; end
      m_seen[idx] = 1;
      if (all_seen()) begin m_busy = 0; m_done = (m_err[0] == 0); end
`ifdef FA_CHK_STOP_ON_ERR_EN
      if (bad) begin m_busy = 0; m_done = 0; end
`endif
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.busy = m_busy; e.done = m_done; e.fail = m_fail; e.cov_full = all_seen();
    e.pass8 = m_pass[0]; e.err8 = m_err[0]; e.pass2 = m_pass[1]; e.err2 = m_err[1];
    e.fvec = m_fvec; e.fgot = m_fgot;
    sb.push_back(e);
  endtask

  // One clock of stimulus; got < 0 means "drive the correct response".
  task automatic cycle(input bit st, input bit v, input int av, input int bv,
                       input int cv, input int got = -1);
    int g;
    g = (got < 0) ? good_sum(av, bv, cv) : got;
    start = st; vld = v;
    a = W'(av); b = W'(bv); cin = cv[0];
    co = g[W]; s = W'(g);
    @(posedge clk);
    model_step(st, v, av, bv, cv, g);
    push_expect();
    #1;
  endtask

  task automatic smp(input int vec, input int got = -1);
    cycle(1'b0, 1'b1, vec >> (W + 1), (vec >> 1) & ((1 << W) - 1), vec & 1, got);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 0; start = 0; vld = 0;
    model_clear();
    m_busy = 0;
    push_expect();
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("busy",     int'(d_busy), int'(e.busy));
      check("done",     int'(d_done), int'(e.done));
      check("fail",     int'(d_fail), int'(e.fail));
      check("cov_full", int'(d_cov),  int'(e.cov_full));
      check("pass_cnt", int'(d_pass), e.pass8);
      check("err_cnt",  int'(d_err),  e.err8);
      check("first_err_vec", int'(d_fvec), e.fvec);
      check("first_err_got", int'(d_fgot), e.fgot);
      check("sat_pass_cnt",  int'(t_pass), e.pass2);
      check("sat_err_cnt",   int'(t_err),  e.err2);
      check("sat_done",      int'(t_done), int'(e.done));
    end
  end

  initial begin
    do_reset();
    cycle(1'b0, 1'b1, 1, 1, 1);              // ignored in IDLE

    // Full correct sweep, then a sample in DONE is ignored.
    cycle(1'b1, 1'b0, 0, 0, 0);
    for (int v = 0; v < NV; v++) smp(v);
    smp(2);

    // Vector 011 answered 01 instead of 10.
    cycle(1'b1, 1'b0, 0, 0, 0);
    for (int v = 0; v < NV; v++) smp(v, (v == 3) ? 1 : -1);
    smp(3);

    // Repeated vector 000, then the rest.
    cycle(1'b1, 1'b0, 0, 0, 0);
    repeat (5) smp(0);
    for (int v = 1; v < NV; v++) smp(v);

    // start with vld mid-run, then reset mid-run.
    cycle(1'b1, 1'b0, 0, 0, 0);
    smp(4); smp(6, 0);
    cycle(1'b1, 1'b1, 1, 1, 0, 0);
    smp(5); smp(7);
    do_reset();

    // Saturation of the CW=2 instance.
    cycle(1'b1, 1'b0, 0, 0, 0);
    repeat (5) smp(5);
    repeat (4) smp(6, 0);

    // Mismatch on the second sample, then six more.
    cycle(1'b1, 1'b0, 0, 0, 0);
    smp(0); smp(1, 0);
    for (int v = 2; v < NV; v++) smp(v);

    // Randomized runs with occasional errors and restarts.
    for (int r = 0; r < 4; r++) begin
      cycle(1'b1, 1'b0, 0, 0, 0);
      for (int i = 0; i < 60; i++) begin
        int vec, g;
        vec = $urandom_range(0, NV - 1);
        g = good_sum(vec >> (W + 1), (vec >> 1) & ((1 << W) - 1), vec & 1);
        if ($urandom_range(0, 15) == 0) g = g ^ $urandom_range(1, (1 << (W + 1)) - 1);
        cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
              vec >> (W + 1), (vec >> 1) & ((1 << W) - 1), vec & 1, g);
      end
    end

    @(negedge clk); #1;
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
